// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM read streamer and its output FIFO.
package ram_stream_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 11;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// Four-entry synchronous FIFO that absorbs RAM read data while the consumer stalls.
module ram_rd_fifo
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
                2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/ram_read_streamer.sv
// Walks a contiguous RAM address range and streams the read words out as
// valid/ready with a last marker. A word moves when m_valid && m_ready at a rising edge.
module ram_read_streamer
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output state_e                state_o
);

    localparam int CRED_W = FIFO_CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
    logic                  enb_q, enb_d;
    logic                  en_dly_q;
    logic                  done_q, done_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [CRED_W-1:0]     credit_used;
    logic                  issue;
    logic                  pop;

    // Reads in flight are exactly the ones sitting in enb_q and en_dly_q.
    assign credit_used = CRED_W'(fifo_count) + CRED_W'(enb_q) + CRED_W'(en_dly_q);
    assign issue       = (state_q == READ) && (issue_cnt_q != '0) &&
                         (credit_used < CRED_W'(FIFO_DEPTH));
    assign pop         = m_valid && m_ready;

    assign m_valid = !fifo_empty;
    assign m_last  = m_valid && (out_cnt_q == LEN_WIDTH'(1));
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign enb     = enb_q;
    assign addrb   = addrb_q;
    assign state_o = state_q;

    ram_rd_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (en_dly_q),
        .pop  (pop),
        .din  (dob),
        .dout (m_data),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        enb_d       = issue;
        addrb_d     = issue ? rd_addr_q : addrb_q;

        if (issue) begin
            rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
            issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
        end
        if (pop) begin
            out_cnt_d = out_cnt_q - LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = READ;
                        rd_addr_d   = base_addr;
                        issue_cnt_d = length;
                        out_cnt_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue_cnt_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (out_cnt_q == LEN_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            addrb_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            enb_q       <= 1'b0;
            en_dly_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            addrb_q     <= addrb_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            enb_q       <= enb_d;
            en_dly_q    <= enb_q;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/ram_read_streamer.md
# ram_read_streamer

Single-clock read sequencer sitting directly downstream of the simple dual-port block RAM, in the read-clock domain. On a start command it walks a contiguous address range, drives the RAM read port (enable and address), absorbs the one-cycle RAM read latency, and presents the words as a valid/ready stream with back-pressure and a last-word marker. A small internal FIFO guarantees that no issued read is lost when the consumer stalls.

## Interface
Parameters:
- ADDR_WIDTH, default 10, RAM address width; range is 2^ADDR_WIDTH words.
- DATA_WIDTH, default 16, RAM word width.
- LEN_WIDTH, default 11, transfer length width; max length 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock, same clock as the RAM read port.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first read address, sampled with start.
- length  in  LEN_WIDTH  number of words, sampled with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at transfer completion.
- enb  out  1  RAM read enable, registered.
- addrb  out  ADDR_WIDTH  RAM read address, registered.
- dob  in  DATA_WIDTH  RAM read data.
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks final word of the transfer, qualified by m_valid.
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both high.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE to READ: start=1 with length>0. Latch base_addr into rd_addr. Latch length into both issue_cnt and out_cnt.
- IDLE with start=1 and length=0: no reads are issued. done pulses on the next cycle; busy stays low.
- start while in READ or DRAIN is ignored.
- READ, read issue: a read is issued in a cycle when issue_cnt>0 and fifo_count + inflight < FIFO_DEPTH (4).
  - On issue, the next cycle has enb=1 and addrb=rd_addr.
  - On issue, rd_addr increments modulo 2^ADDR_WIDTH and issue_cnt decrements.
- READ to DRAIN: when issue_cnt reaches 0.
- Read data capture: a read driven with enb=1 in cycle n presents dob in cycle n+1. A one-bit delayed enb pushes dob into the FIFO at the end of cycle n+1.
- inflight counts issued reads whose data is not yet pushed; maximum 2.
- Output side:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - Each handshake pops the FIFO and decrements out_cnt.
  - m_last = (out_cnt == 1).
- DRAIN to IDLE: on the handshake of the last word. done pulses the following cycle and busy drops in that same cycle.
- Push and pop in the same cycle are legal; fifo_count is unchanged.
- The FIFO never overflows because of the credit rule. A push into a full FIFO is an assertion failure.

## Timing
- Reset values: busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0.
- Reset clears the FIFO, all counters and the state to IDLE, including mid-transfer. In-flight RAM data arriving after reset is discarded.
- Latency with m_ready held high:
  - start accepted at edge 0; enb=1 in cycle 1.
  - First m_valid in cycle 3.
  - Steady state is 1 word/cycle.
  - Last handshake occurs in cycle 2+length; done is in cycle 3+length.
- When m_ready is low, issue halts once fifo_count + inflight = 4. Issue resumes the cycle after a pop frees credit.
- Address wrap: base_addr=1022 with length=4 reads 1022, 1023, 0, 1.

## Structure
- Package ram_stream_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - FIFO_DEPTH=4;
  - default ADDR_WIDTH, DATA_WIDTH and LEN_WIDTH constants.
- Sub-module ram_rd_fifo: 4-entry synchronous FIFO.
  - Ports: push, pop, din, dout, empty, full, count.
  - Same clk and rst.
- The top level holds the FSM, counters, credit logic and the delayed-enable register.

## Test plan
- Reset, then start with base=0x010 and length=8, m_ready=1. Expect:
  - enb in cycles 1–8 with addresses 0x010–0x017;
  - 8 words in cycles 3–10, m_last on the 8th;
  - done in cycle 11.
- base=0x3FE, length=4. Expect addrb sequence 0x3FE, 0x3FF, 0x000, 0x001 and matching data.
- Back-pressure: length=10 with m_ready toggling 2 cycles low, 1 high. Expect:
  - fifo_count + inflight never exceeds 4;
  - all 10 words in order with no duplicates;
  - m_data held stable while stalled.
- length=0. Expect done pulse next cycle, enb never asserted, busy stays 0.
- start pulsed again mid-transfer with a different base. Expect it ignored; the original sequence completes unchanged.
- rst asserted for 1 cycle mid-transfer (after 3 words). Expect:
  - all outputs return to reset values immediately;
  - no stray m_valid after reset;
  - a subsequent start with length=2 works normally.
